// File: rtl/ram_copy_pkg.sv
// Shared types for the RAM-to-RAM copy engine.
package ram_copy_pkg;

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

endpackage

// File: rtl/ram_copy_dma.sv
// Word-per-cycle copy engine between two external RAMs: asynchronous-read source,
// synchronous-write destination, one pipeline stage between read and write.
module ram_copy_dma
  import ram_copy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 8,
  localparam int unsigned AW = $clog2(RAM_DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_start,
  input  logic [AW-1:0]         i_src_addr,
  input  logic [AW-1:0]         i_dst_addr,
  input  logic [LW-1:0]         i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [AW-1:0]         o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_wr_en,
  output logic [AW-1:0]         o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data
);

  state_t                state_q, state_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [AW-1:0]         dst_q, dst_d;
  logic [LW-1:0]         left_q, left_d;
  logic                  pipe_vld_q, pipe_vld_d;
  logic [AW-1:0]         pipe_addr_q, pipe_addr_d;
  logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic [LW-1:0]         len_sat;

  // Explicit wrap so non-power-of-two depths stay inside the RAM.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(RAM_DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  assign len_sat = (i_len > LW'(RAM_DEPTH)) ? LW'(RAM_DEPTH) : i_len;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    dst_d       = dst_q;
    left_d      = left_q;
    pipe_vld_d  = 1'b0;
    pipe_addr_d = pipe_addr_q;
    pipe_data_d = pipe_data_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          rd_addr_d = i_src_addr;
          dst_d     = i_dst_addr;
          left_d    = len_sat;
          state_d   = (len_sat == '0) ? DONE : COPY;
        end
      end
      COPY: begin
        // Capture word k now; it is written next cycle while word k+1 is read.
        pipe_vld_d  = 1'b1;
        pipe_data_d = i_rd_data;
        pipe_addr_d = dst_q;
        dst_d       = addr_inc(dst_q);
        rd_addr_d   = addr_inc(rd_addr_q);
        left_d      = left_q - LW'(1);
        if (left_q == LW'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_addr_q   <= '0;
      dst_q       <= '0;
      left_q      <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_data_q <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      dst_q       <= dst_d;
      left_q      <= left_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_rd_en   = (state_q == COPY);
  assign o_rd_addr = o_rd_en ? rd_addr_q : '0;
  assign o_wr_en   = pipe_vld_q;
  assign o_wr_addr = pipe_vld_q ? pipe_addr_q : '0;
  assign o_wr_data = pipe_vld_q ? pipe_data_q : '0;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Self-checking bench for ram_copy_dma: directed and random copies against a memmove model.
module tb_ram_copy_dma;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_src_addr = '0;
  logic [AW-1:0] i_dst_addr = '0;
  logic [AW:0]   i_len = '0;
  logic          o_busy, o_done, o_rd_en, o_wr_en;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [DW-1:0] i_rd_data, o_wr_data;

  logic [DW-1:0] src_mem [D];
  logic [DW-1:0] dst_mem [D];
  logic [DW-1:0] src_img [D];
  logic [DW-1:0] dst_img [D];
  logic          same_ram = 1'b0;
  logic          load_req = 1'b0;

  int checks = 0;
  int errors = 0;
  int rd_n = 0;
  int wr_n = 0;
  int done_n = 0;
  int rd_log [1024];
  int wa_log [1024];
  int wd_log [1024];

  ram_copy_dma #(.DATA_WIDTH(DW), .RAM_DEPTH(D)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_start   (i_start),
    .i_src_addr(i_src_addr),
    .i_dst_addr(i_dst_addr),
    .i_len     (i_len),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data)
  );

  always #5 clk = ~clk;

  assign i_rd_data = !o_rd_en ? '0 : (same_ram ? dst_mem[o_rd_addr] : src_mem[o_rd_addr]);

  // External RAMs plus activity logs.
  always @(posedge clk) begin
    if (load_req) begin
      src_mem <= src_img;
      dst_mem <= dst_img;
    end else if (o_wr_en) begin
      dst_mem[o_wr_addr] <= o_wr_data;
    end
    if (o_rd_en && rd_n < 1024) begin
      rd_log[rd_n] = int'(o_rd_addr);
      rd_n++;
    end
    if (o_wr_en && wr_n < 1024) begin
      wa_log[wr_n] = int'(o_wr_addr);
      wd_log[wr_n] = int'(o_wr_data);
      wr_n++;
    end
    if (o_done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_rd_en"}, 32'(o_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(o_rd_addr), 0);
    chk({tag, "_wr_en"}, 32'(o_wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(o_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(o_wr_data), 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic load_mem();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_copy(input int src, input int dst, input int len, input bit same,
                          input bit hold);
    logic [DW-1:0] snap [D];
    logic [DW-1:0] expm [D];
    int n, r0, w0, d0, lat;
    n = (len > D) ? D : len;
    for (int k = 0; k < n; k++) snap[k] = same ? dst_img[(src + k) % D] : src_img[(src + k) % D];
    expm = dst_img;
    for (int k = 0; k < n; k++) expm[(dst + k) % D] = snap[k];
    r0 = rd_n;
    w0 = wr_n;
    d0 = done_n;
    lat = 0;
    same_ram   = same;
    i_src_addr = AW'(src);
    i_dst_addr = AW'(dst);
    i_len      = (AW + 1)'(len);
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) i_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk("busy_during", 32'(o_busy), 1);
      if (!o_rd_en) chk("rd_addr_gate", 32'(o_rd_addr), 0);
      if (!o_wr_en) chk("wr_gate", {16'(o_wr_addr), 16'(o_wr_data)}, 0);
      if (o_done) begin
        lat = c;
        chk("done_no_access", {31'(0), o_rd_en | o_wr_en}, 0);
        i_start = 1'b0;
        break;
      end
    end
    chk("done_latency", lat, (n == 0) ? 1 : n + 2);
    @(negedge clk);
    chk("busy_after", 32'(o_busy), 0);
    chk("done_pulse", 32'(o_done), 0);
    if (hold) repeat (4) begin
      @(negedge clk);
      chk("no_restart", {31'(0), o_busy | o_rd_en}, 0);
    end
    chk("done_count", done_n - d0, 1);
    chk("read_count", rd_n - r0, n);
    chk("write_count", wr_n - w0, n);
    for (int k = 0; k < n && r0 + k < rd_n; k++) chk("read_addr", rd_log[r0 + k], (src + k) % D);
    for (int k = 0; k < n && w0 + k < wr_n; k++) begin
      chk("write_addr", wa_log[w0 + k], (dst + k) % D);
      chk("write_data", wd_log[w0 + k], 32'(snap[k]));
    end
    for (int a = 0; a < D; a++) chk("dst_mem", 32'(dst_mem[a]), 32'(expm[a]));
    dst_img = dst_mem;
  endtask

  task automatic rand_images();
    for (int a = 0; a < D; a++) begin
      src_img[a] = DW'($urandom);
      dst_img[a] = DW'($urandom);
    end
  endtask

  initial begin
    int w0, d0, s, d, l;
    bit sm;
    for (int a = 0; a < D; a++) begin
      src_img[a] = '0;
      dst_img[a] = '0;
    end
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Full-depth copy into a separate RAM.
    for (int a = 0; a < D; a++) src_img[a] = DW'(8'h10 + a);
    load_mem();
    run_copy(0, 0, 8, 1'b0, 1'b0);

    // Zero length.
    run_copy(3, 4, 0, 1'b0, 1'b0);

    // Wrapping source and destination.
    rand_images();
    load_mem();
    run_copy(6, 5, 4, 1'b0, 1'b0);

    // Overlapping forward copy within one RAM.
    for (int a = 0; a < D; a++) dst_img[a] = DW'(8'h80 + a);
    for (int a = 3; a < 8; a++) dst_img[a] = DW'(8'hA + a - 3);
    load_mem();
    run_copy(3, 2, 5, 1'b1, 1'b0);

    // Start held high, oversize length saturates.
    rand_images();
    load_mem();
    run_copy(1, 2, 12, 1'b0, 1'b1);

    // Reset mid-copy: two words already written, then abort.
    rand_images();
    load_mem();
    w0 = wr_n;
    d0 = done_n;
    same_ram   = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_len      = 4'd8;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk_outputs_zero("abort");
    repeat (2) @(negedge clk);
    chk_outputs_zero("abort_hold");
    chk("abort_writes", wr_n - w0, 2);
    chk("abort_done", done_n - d0, 0);
    for (int a = 0; a < D; a++) chk("abort_mem", 32'(dst_mem[a]), 32'((a < 2) ? src_img[a] : dst_img[a]));
    dst_img = dst_mem;
    n_rst = 1'b1;
    run_copy(2, 3, 5, 1'b0, 1'b0);

    // Random copies.
    for (int it = 0; it < 10; it++) begin
      rand_images();
      load_mem();
      sm = 1'($urandom);
      if (sm) begin
        s = int'($urandom_range(0, D - 1));
        d = int'($urandom_range(0, s));
        l = int'($urandom_range(0, D - s));
      end else begin
        s = int'($urandom_range(0, D - 1));
        d = int'($urandom_range(0, D - 1));
        l = int'($urandom_range(0, 12));
      end
      run_copy(s, d, l, sm, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
